// File: rtl/knn_pkg.sv
// knn_pkg: shared sizes, FSM state encoding and address helper for the kNN
// query sequencer. The optional squared-distance mode is selected with the
// KNN_SQ_DIST_EN macro in knn_dist_accum.
package knn_pkg;

  localparam int DATA_WIDTH   = 16;
  localparam int NUM_FEATURES = 4;
  localparam int NUM_SAMPLES  = 16;
  localparam int K            = 5;
  localparam int DIST_W       = 32;

  localparam int IDX_W  = $clog2(NUM_SAMPLES);
  localparam int FEAT_W = $clog2(NUM_FEATURES);
  localparam int MEM_AW = $clog2(NUM_SAMPLES * NUM_FEATURES);

  typedef enum logic [2:0] {
    IDLE,
    LOAD_TEST,
    CLEAR_SEL,
    COMPUTE,
    EMIT,
    WAIT_SEL,
    WRITEBACK,
    FINISH
  } state_t;

  // Flat sample-memory address: samples are laid out NUM_FEATURES apart.
  function automatic logic [MEM_AW-1:0] sample_addr(input logic [IDX_W-1:0]  s,
                                                    input logic [FEAT_W-1:0] f);
    logic [MEM_AW-1:0] base;
    base = MEM_AW'(s) * MEM_AW'(NUM_FEATURES);
    return base + MEM_AW'(f);
  endfunction

endpackage

// File: rtl/knn_dist_accum.sv
// knn_dist_accum: per-feature distance term and saturating accumulator.
// Default build: term = |sample - test| (L1), accumulated in the cycle the
// data arrives. With KNN_SQ_DIST_EN defined: term = (sample - test)^2 in
// 2*DATA_WIDTH bits, registered one stage before accumulation.
// acc_done pulses the cycle after the last term has been folded into acc.
module knn_dist_accum
  import knn_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  input  logic                  in_first,
  input  logic                  in_last,
  input  logic [DATA_WIDTH-1:0] in_sample,
  input  logic [DATA_WIDTH-1:0] in_test,
  output logic [DIST_W-1:0]     acc,
  output logic                  acc_done
);

  logic [DATA_WIDTH-1:0] abs_diff;
  assign abs_diff = (in_sample >= in_test) ? (in_sample - in_test) : (in_test - in_sample);

`ifdef KNN_SQ_DIST_EN
  localparam int TERM_W = 2 * DATA_WIDTH;

  logic [TERM_W-1:0] term_q;
  logic              term_vld_q;
  logic              term_first_q;
  logic              term_last_q;

  // Square stage: breaks the multiplier away from the accumulator adder.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      term_q       <= '0;
      term_vld_q   <= 1'b0;
      term_first_q <= 1'b0;
      term_last_q  <= 1'b0;
    end else begin
      term_vld_q   <= in_valid;
      term_first_q <= in_first;
      term_last_q  <= in_last;
      if (in_valid) begin
        term_q <= TERM_W'(abs_diff) * TERM_W'(abs_diff);
      end
    end
  end

  logic [TERM_W-1:0] term;
  logic              term_vld;
  logic              term_first;
  logic              term_last;
  assign term       = term_q;
  assign term_vld   = term_vld_q;
  assign term_first = term_first_q;
  assign term_last  = term_last_q;
`else
  localparam int TERM_W = DATA_WIDTH;

  logic [TERM_W-1:0] term;
  logic              term_vld;
  logic              term_first;
  logic              term_last;
  assign term       = abs_diff;
  assign term_vld   = in_valid;
  assign term_first = in_first;
  assign term_last  = in_last;
`endif

  // One spare bit above the wider operand catches any overflow of the add.
  localparam int SUM_W = ((TERM_W > DIST_W) ? TERM_W : DIST_W) + 1;

  logic [SUM_W-1:0] sum;
  assign sum = (term_first ? '0 : SUM_W'(acc)) + SUM_W'(term);

  function automatic logic [DIST_W-1:0] saturate(input logic [SUM_W-1:0] v);
    if (v > SUM_W'({DIST_W{1'b1}})) begin
      return '1;
    end
    return v[DIST_W-1:0];
  endfunction

  // Accumulate; the first feature of a sample restarts the running sum.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc      <= '0;
      acc_done <= 1'b0;
    end else begin
      acc_done <= term_vld & term_last;
      if (term_vld) begin
        acc <= saturate(sum);
      end
    end
  end

endmodule

// File: rtl/knn_query_sequencer.sv
// knn_query_sequencer: runs one kNN query: loads the test vector, streams one
// distance per training sample into the selector, then writes back the K
// best indices. Distance metric is L1 unless KNN_SQ_DIST_EN is defined
// (squared Euclidean, one extra pipeline cycle per sample).
//
// state     | meaning
// ----------+---------------------------------------------------------
// IDLE      | waiting for start; cfg latched on accept
// LOAD_TEST | reading test vector features 0..nf-1 into test_reg
// CLEAR_SEL | sel_clear pulse, then sel_start pulse
// COMPUTE   | reading sample s features, accumulating its distance
// EMIT      | dist_valid held with distance of sample s until ready
// WAIT_SEL  | waiting for selector to report done
// WRITEBACK | writing K selector indices to the kbest buffer
// FINISH    | done pulse, back to IDLE
module knn_query_sequencer
  import knn_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  abort,
  input  logic [IDX_W-1:0]      cfg_num_samples,
  input  logic [FEAT_W-1:0]     cfg_num_features,
  output logic                  busy,
  output logic                  done,
  output logic                  test_ren,
  output logic [FEAT_W-1:0]     test_raddr,
  input  logic [DATA_WIDTH-1:0] test_rdata_q,
  output logic                  sample_ren,
  output logic [MEM_AW-1:0]     sample_raddr,
  input  logic [DATA_WIDTH-1:0] sample_rdata_q,
  output logic                  kbest_wen,
  output logic [IDX_W-1:0]      kbest_waddr,
  output logic [IDX_W-1:0]      kbest_wdata,
  output logic                  sel_start,
  output logic                  sel_clear,
  output logic                  dist_valid,
  output logic [DIST_W-1:0]     dist_data,
  output logic [IDX_W-1:0]      dist_index,
  input  logic                  dist_ready,
  input  logic                  sel_done,
  input  logic [K*IDX_W-1:0]    sel_indices_bus
);

  state_t                  state;
  logic [IDX_W-1:0]        ns_last;
  logic [FEAT_W-1:0]       nf_last;
  logic [IDX_W-1:0]        s_cnt;
  logic [FEAT_W-1:0]       f_cnt;
  logic [K*IDX_W-1:0]      idx_q;

  logic [DATA_WIDTH-1:0]   test_reg [NUM_FEATURES];
  logic                    test_vld;
  logic [FEAT_W-1:0]       test_vidx;
  logic                    smp_vld;
  logic [FEAT_W-1:0]       smp_feat;
  logic                    smp_first;
  logic                    smp_last;

  logic [DIST_W-1:0]       acc;
  logic                    acc_done;
  logic [IDX_W-1:0]        wb_next;

  assign wb_next = kbest_waddr + 1'b1;

  // Track reads in flight so returned data lines up with its feature index.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      test_vld  <= 1'b0;
      test_vidx <= '0;
      smp_vld   <= 1'b0;
      smp_feat  <= '0;
      smp_first <= 1'b0;
      smp_last  <= 1'b0;
      for (int i = 0; i < NUM_FEATURES; i++) begin
        test_reg[i] <= '0;
      end
    end else begin
      test_vld  <= test_ren;
      test_vidx <= test_raddr;
      smp_vld   <= sample_ren;
      smp_feat  <= f_cnt;
      smp_first <= (f_cnt == '0);
      smp_last  <= (f_cnt == nf_last);
      if (test_vld) begin
        test_reg[test_vidx] <= test_rdata_q;
      end
    end
  end

  // Returned sample data only counts while a sample is being computed, so
  // reads stranded by an abort never reach the accumulator.
  knn_dist_accum u_accum (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (smp_vld && (state == COMPUTE)),
    .in_first  (smp_first),
    .in_last   (smp_last),
    .in_sample (sample_rdata_q),
    .in_test   (test_reg[smp_feat]),
    .acc       (acc),
    .acc_done  (acc_done)
  );

  // Query sequencing FSM with registered strobes and handshake outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      ns_last      <= '0;
      nf_last      <= '0;
      s_cnt        <= '0;
      f_cnt        <= '0;
      idx_q        <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      test_ren     <= 1'b0;
      test_raddr   <= '0;
      sample_ren   <= 1'b0;
      sample_raddr <= '0;
      kbest_wen    <= 1'b0;
      kbest_waddr  <= '0;
      kbest_wdata  <= '0;
      sel_start    <= 1'b0;
      sel_clear    <= 1'b0;
      dist_valid   <= 1'b0;
      dist_data    <= '0;
      dist_index   <= '0;
    end else begin
      sel_clear <= 1'b0;
      sel_start <= 1'b0;
      done      <= 1'b0;
      if (abort && (state != IDLE)) begin
        // Leave the selector clean for the next query.
        state      <= IDLE;
        busy       <= 1'b0;
        test_ren   <= 1'b0;
        sample_ren <= 1'b0;
        kbest_wen  <= 1'b0;
        dist_valid <= 1'b0;
        sel_clear  <= 1'b1;
      end else begin
        case (state)
          IDLE: begin
            if (start && !abort) begin
              ns_last    <= (cfg_num_samples == '0) ? IDX_W'(NUM_SAMPLES - 1)
                                                    : cfg_num_samples - 1'b1;
              nf_last    <= (cfg_num_features == '0) ? FEAT_W'(NUM_FEATURES - 1)
                                                     : cfg_num_features - 1'b1;
              busy       <= 1'b1;
              test_ren   <= 1'b1;
              test_raddr <= '0;
              state      <= LOAD_TEST;
            end
          end
          LOAD_TEST: begin
            if (test_ren) begin
              if (test_raddr == nf_last) begin
                test_ren <= 1'b0;
              end else begin
                test_raddr <= test_raddr + 1'b1;
              end
            end else begin
              // Last feature is being captured this cycle.
              sel_clear <= 1'b1;
              state     <= CLEAR_SEL;
            end
          end
          CLEAR_SEL: begin
            if (sel_clear) begin
              sel_start <= 1'b1;
            end else begin
              s_cnt        <= '0;
              f_cnt        <= '0;
              sample_ren   <= 1'b1;
              sample_raddr <= sample_addr('0, '0);
              state        <= COMPUTE;
            end
          end
          COMPUTE: begin
            if (sample_ren) begin
              if (f_cnt == nf_last) begin
                sample_ren <= 1'b0;
              end else begin
                f_cnt        <= f_cnt + 1'b1;
                sample_raddr <= sample_addr(s_cnt, f_cnt + 1'b1);
              end
            end
            if (acc_done) begin
              dist_valid <= 1'b1;
              dist_data  <= acc;
              dist_index <= s_cnt;
              state      <= EMIT;
            end
          end
          EMIT: begin
            if (dist_ready) begin
              dist_valid <= 1'b0;
              if (s_cnt == ns_last) begin
                state <= WAIT_SEL;
              end else begin
                s_cnt        <= s_cnt + 1'b1;
                f_cnt        <= '0;
                sample_ren   <= 1'b1;
                sample_raddr <= sample_addr(s_cnt + 1'b1, '0);
                state        <= COMPUTE;
              end
            end
          end
          WAIT_SEL: begin
            if (sel_done) begin
              idx_q       <= sel_indices_bus;
              kbest_wen   <= 1'b1;
              kbest_waddr <= '0;
              kbest_wdata <= sel_indices_bus[IDX_W-1:0];
              state       <= WRITEBACK;
            end
          end
          WRITEBACK: begin
            if (kbest_waddr == IDX_W'(K - 1)) begin
              kbest_wen <= 1'b0;
              done      <= 1'b1;
              busy      <= 1'b0;
              state     <= FINISH;
            end else begin
              kbest_waddr <= wb_next;
              kbest_wdata <= idx_q[int'(wb_next) * IDX_W +: IDX_W];
            end
          end
          FINISH: begin
            state <= IDLE;
          end
          default: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_knn_query_sequencer.sv
// Self-checking bench for knn_query_sequencer: registered memory model,
// stub selector, and a scoreboard of expected reads, distances and writes.
module tb_knn_query_sequencer;
  import knn_pkg::*;

  logic                  clk = 1'b0;
  logic                  rst = 1'b1;
  logic                  start = 1'b0;
  logic                  abort = 1'b0;
  logic [IDX_W-1:0]      cfg_num_samples = '0;
  logic [FEAT_W-1:0]     cfg_num_features = '0;
  logic                  busy, done;
  logic                  test_ren;
  logic [FEAT_W-1:0]     test_raddr;
  logic [DATA_WIDTH-1:0] test_rdata_q = '0;
  logic                  sample_ren;
  logic [MEM_AW-1:0]     sample_raddr;
  logic [DATA_WIDTH-1:0] sample_rdata_q = '0;
  logic                  kbest_wen;
  logic [IDX_W-1:0]      kbest_waddr, kbest_wdata;
  logic                  sel_start, sel_clear;
  logic                  dist_valid;
  logic [DIST_W-1:0]     dist_data;
  logic [IDX_W-1:0]      dist_index;
  logic                  dist_ready = 1'b0;
  logic                  sel_done = 1'b0;
  logic [K*IDX_W-1:0]    sel_indices_bus = '0;

  knn_query_sequencer dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .cfg_num_samples(cfg_num_samples), .cfg_num_features(cfg_num_features),
    .busy(busy), .done(done),
    .test_ren(test_ren), .test_raddr(test_raddr), .test_rdata_q(test_rdata_q),
    .sample_ren(sample_ren), .sample_raddr(sample_raddr), .sample_rdata_q(sample_rdata_q),
    .kbest_wen(kbest_wen), .kbest_waddr(kbest_waddr), .kbest_wdata(kbest_wdata),
    .sel_start(sel_start), .sel_clear(sel_clear),
    .dist_valid(dist_valid), .dist_data(dist_data), .dist_index(dist_index),
    .dist_ready(dist_ready), .sel_done(sel_done), .sel_indices_bus(sel_indices_bus)
  );

  always #5 clk = ~clk;

  logic [DATA_WIDTH-1:0] test_mem [NUM_FEATURES];
  logic [DATA_WIDTH-1:0] smp_mem  [NUM_SAMPLES*NUM_FEATURES];

  // Memories with one cycle of read latency.
  always @(posedge clk) begin
    if (test_ren)   test_rdata_q   <= test_mem[test_raddr];
    if (sample_ren) sample_rdata_q <= smp_mem[sample_raddr];
  end

  int n_assert = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
    end
  endtask

  // Reference distance from the memory contents.
  function automatic longint model_dist(int s, int nf);
    longint total, d, dmax;
    dmax  = (longint'(1) << DIST_W) - 1;
    total = 0;
    for (int f = 0; f < nf; f++) begin
      d = longint'(smp_mem[s*NUM_FEATURES + f]) - longint'(test_mem[f]);
      if (d < 0) d = -d;
`ifdef KNN_SQ_DIST_EN
      d = d * d;
`endif
      total = total + d;
      if (total > dmax) total = dmax;
    end
    return total;
  endfunction

  int     exp_taddr[$];
  int     exp_raddr[$];
  int     exp_idx[$];
  longint exp_dist[$];
  int     exp_kb[$];
  int     xfer_cnt = 0;
  int     wr_cnt = 0;
  bit     done_seen = 0;
  bit     done_ok = 0;
  bit     mon_en = 0;
  bit     prev_stall = 0;
  bit     prev_abort = 0;
  logic [DIST_W-1:0] prev_data = '0;
  logic [IDX_W-1:0]  prev_idx = '0;
  int     ready_mode = 0;
  int     rcyc = 0;

  // Stub selector ready: always, one-in-three, or stall on sample 7.
  always @(posedge clk) begin
    #1;
    rcyc++;
    case (ready_mode)
      1:       dist_ready = (rcyc % 3 == 0);
      2:       dist_ready = !(dist_valid && dist_index == 7);
      default: dist_ready = 1'b1;
    endcase
  end

  // Compare process: checks every observable event against the scoreboard.
  always @(negedge clk) begin
    if (mon_en) begin
      if (prev_stall && !prev_abort) begin
        chk("hold_valid", dist_valid, 1);
        chk("hold_data", dist_data, prev_data);
        chk("hold_index", dist_index, prev_idx);
      end
      if (dist_valid) chk("valid_implies_busy", busy, 1);
      if (dist_valid && dist_ready) begin
        chk("dist_expected", exp_dist.size() > 0, 1);
        if (exp_dist.size() > 0) begin
          chk("dist_index", dist_index, exp_idx.pop_front());
          chk("dist_data", dist_data, exp_dist.pop_front());
        end
        xfer_cnt++;
      end
      prev_stall = dist_valid && !dist_ready;
      prev_data  = dist_data;
      prev_idx   = dist_index;
      prev_abort = abort;
      if (test_ren) begin
        chk("test_read_expected", exp_taddr.size() > 0, 1);
        if (exp_taddr.size() > 0) chk("test_raddr", test_raddr, exp_taddr.pop_front());
      end
      if (sample_ren) begin
        chk("sample_read_expected", exp_raddr.size() > 0, 1);
        if (exp_raddr.size() > 0) chk("sample_raddr", sample_raddr, exp_raddr.pop_front());
      end
      if (kbest_wen) begin
        chk("kbest_write_expected", exp_kb.size() > 0, 1);
        if (exp_kb.size() > 0)
          chk("kbest_addr_data", (int'(kbest_waddr) << IDX_W) | int'(kbest_wdata), exp_kb.pop_front());
        wr_cnt++;
      end
      if (done) begin
        chk("done_allowed", done_ok, 1);
        chk("done_write_count", wr_cnt, K);
        chk("done_reads_drained", exp_raddr.size(), 0);
        done_seen = 1;
        done_ok   = 0;
      end
    end
  end

  task automatic run_query(input string tag, input int ns_cfg, input int nf_cfg, input int rmode,
                           input logic [K*IDX_W-1:0] bus, input bit extra_start, input bit spurious);
    int ns, nf, cyc;
    ns = (ns_cfg == 0) ? NUM_SAMPLES : ns_cfg;
    nf = (nf_cfg == 0) ? NUM_FEATURES : nf_cfg;
    exp_taddr.delete(); exp_raddr.delete(); exp_idx.delete(); exp_dist.delete(); exp_kb.delete();
    for (int f = 0; f < nf; f++) exp_taddr.push_back(f);
    for (int s = 0; s < ns; s++) begin
      for (int f = 0; f < nf; f++) exp_raddr.push_back(s*NUM_FEATURES + f);
      exp_idx.push_back(s);
      exp_dist.push_back(model_dist(s, nf));
    end
    for (int i = 0; i < K; i++) exp_kb.push_back((i << IDX_W) | int'(bus[i*IDX_W +: IDX_W]));
    ready_mode = rmode; xfer_cnt = 0; wr_cnt = 0; done_seen = 0; done_ok = 0;
    sel_indices_bus = ~bus;
    cfg_num_samples  = IDX_W'(ns_cfg);
    cfg_num_features = FEAT_W'(nf_cfg);
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    chk({tag, "_busy_after_start"}, busy, 1);
    cyc = 0;
    while (xfer_cnt < ns && cyc < 3000) begin
      @(posedge clk); #1;
      cyc++;
      start    = extra_start && (cyc == 20);
      sel_done = spurious && (cyc == 3);
    end
    start = 1'b0; sel_done = 1'b0;
    chk({tag, "_transfers"}, xfer_cnt, ns);
    repeat (2) @(posedge clk);
    #1 sel_indices_bus = bus; sel_done = 1'b1; done_ok = 1;
    @(posedge clk); #1 sel_done = 1'b0; sel_indices_bus = ~bus;
    cyc = 0;
    while (!done_seen && cyc < 50) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk({tag, "_done_seen"}, done_seen, 1);
    chk({tag, "_dist_drained"}, exp_dist.size(), 0);
    @(posedge clk); #1;
    chk({tag, "_busy_after_done"}, busy, 0);
    chk({tag, "_done_is_pulse"}, done, 0);
  endtask

  function automatic void load_ramp();
    for (int f = 0; f < NUM_FEATURES; f++) test_mem[f] = DATA_WIDTH'(100 + f);
    for (int s = 0; s < NUM_SAMPLES; s++)
      for (int f = 0; f < NUM_FEATURES; f++) smp_mem[s*NUM_FEATURES + f] = DATA_WIDTH'(10*s + f);
  endfunction

  initial begin
    int cyc;
    load_ramp();
    #12;
    @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_test_ren", test_ren, 0);
    chk("rst_sample_ren", sample_ren, 0);
    chk("rst_kbest_wen", kbest_wen, 0);
    chk("rst_sel_start", sel_start, 0);
    chk("rst_sel_clear", sel_clear, 0);
    chk("rst_dist_valid", dist_valid, 0);
    chk("rst_dist_data", dist_data, 0);
    @(posedge clk); #1 rst = 1'b0;
    mon_en = 1;

    // Pin the model with hand-derived values.
`ifdef KNN_SQ_DIST_EN
    chk("model_s10", model_dist(10, 4), 0);
    chk("model_s9", model_dist(9, 4), 400);
    chk("model_s0", model_dist(0, 4), 40000);
    chk("model_cfg_s1", model_dist(1, 2), 16200);
`else
    chk("model_s10", model_dist(10, 4), 0);
    chk("model_s9", model_dist(9, 4), 40);
    chk("model_s0", model_dist(0, 4), 400);
    chk("model_cfg_s0", model_dist(0, 2), 200);
    chk("model_cfg_s1", model_dist(1, 2), 180);
    chk("model_cfg_s2", model_dist(2, 2), 160);
`endif

    // start and abort together in IDLE: nothing happens.
    @(posedge clk); #1 start = 1'b1; abort = 1'b1;
    @(posedge clk); #1 start = 1'b0; abort = 1'b0;
    chk("start_abort_idle_busy", busy, 0);

    run_query("full", 0, 0, 0, {4'd12, 4'd8, 4'd11, 4'd9, 4'd10}, 0, 1);
    run_query("bp", 0, 0, 1, {4'd1, 4'd2, 4'd3, 4'd4, 4'd5}, 1, 0);
    run_query("cfg", 3, 2, 0, {4'd0, 4'd0, 4'd0, 4'd1, 4'd2}, 0, 0);

    // Abort while sample 7 is waiting in EMIT.
    exp_taddr.delete(); exp_raddr.delete(); exp_idx.delete(); exp_dist.delete(); exp_kb.delete();
    for (int f = 0; f < NUM_FEATURES; f++) exp_taddr.push_back(f);
    for (int s = 0; s < NUM_SAMPLES; s++) begin
      for (int f = 0; f < NUM_FEATURES; f++) exp_raddr.push_back(s*NUM_FEATURES + f);
      exp_idx.push_back(s);
      exp_dist.push_back(model_dist(s, NUM_FEATURES));
    end
    ready_mode = 2; xfer_cnt = 0; wr_cnt = 0; done_ok = 0;
    cfg_num_samples = '0; cfg_num_features = '0;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    cyc = 0;
    while (!(dist_valid && dist_index == 7) && cyc < 2000) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk("abort_reached_s7", dist_valid && dist_index == 7, 1);
    chk("abort_prior_xfers", xfer_cnt, 7);
    abort = 1'b1;
    @(posedge clk); #1 abort = 1'b0;
    chk("abort_dist_valid", dist_valid, 0);
    chk("abort_sel_clear", sel_clear, 1);
    chk("abort_busy", busy, 0);
    chk("abort_sample_ren", sample_ren, 0);
    chk("abort_done", done, 0);
    @(posedge clk); #1;
    chk("abort_sel_clear_pulse", sel_clear, 0);
    repeat (30) @(posedge clk);
    chk("abort_no_writes", wr_cnt, 0);

    run_query("after_abort", 0, 0, 0, {4'd7, 4'd6, 4'd5, 4'd4, 4'd3}, 0, 0);

    // Saturation corner: all-ones samples against a zero test vector.
    for (int f = 0; f < NUM_FEATURES; f++) begin
      test_mem[f] = '0;
      smp_mem[f]  = '1;
    end
`ifdef KNN_SQ_DIST_EN
    chk("model_sat", model_dist(0, 4), 64'hFFFF_FFFF);
`else
    chk("model_sat", model_dist(0, 4), 262140);
`endif
    run_query("sat", 1, 0, 0, {4'd0, 4'd0, 4'd0, 4'd0, 4'd0}, 0, 0);

    mon_en = 0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/knn_query_sequencer.md
Name: knn_query_sequencer

Overview:
Controller that runs one kNN query end to end. It reads the test vector and every training sample from knn_memory, computes L1 distances, and streams them into kbest_selector_wrap over the valid/ready handshake. When the selector reports done, it writes the K best indices into the memory's kbest buffer. The block sits between the host/config logic and the memory plus selector datapath, and owns all of their read/write/start/clear strobes during a query.

Parameters:
DATA_WIDTH, 16, feature element width (unsigned)
NUM_FEATURES, 4, max features per sample
NUM_SAMPLES, 16, max training samples
K, 5, number of neighbours
DIST_W, 32, distance width
IDX_W, 4, sample index width (clog2 NUM_SAMPLES)
FEAT_W, 2, feature index width (clog2 NUM_FEATURES)
MEM_AW, 6, flat sample-memory address width (clog2 NUM_SAMPLES*NUM_FEATURES)

Ports:
clk  in  1  clock
rst  in  1  async active-high reset
start  in  1  one-cycle query request; ignored while busy
abort  in  1  cancel the running query
cfg_num_samples  in  IDX_W  active samples; 0 means NUM_SAMPLES
cfg_num_features  in  FEAT_W  active features; 0 means NUM_FEATURES
busy  out  1  high from accepted start until done/abort
done  out  1  one-cycle pulse when writeback completes
test_ren / test_raddr / test_rdata_q  out/out/in  1/FEAT_W/DATA_WIDTH  test-vector read port
sample_ren / sample_raddr / sample_rdata_q  out/out/in  1/MEM_AW/DATA_WIDTH  sample read port
kbest_wen / kbest_waddr / kbest_wdata  out/out/out  1/IDX_W/IDX_W  kbest buffer write
sel_start / sel_clear  out/out  1/1  selector control pulses
dist_valid / dist_data / dist_index  out/out/out  1/DIST_W/IDX_W  distance stream
dist_ready  in  1  selector ready
sel_done  in  1  selector finished
sel_indices_bus  in  K*IDX_W  selector result; entry i at [(i+1)*IDX_W-1 : i*IDX_W]

Behaviour:
- Reset: all outputs 0; FSM in IDLE; counters and test registers cleared.
- Memory read latency is 1 cycle: data is registered and valid in the cycle after ren.
- IDLE: on start, latch cfg values (0 maps to max), set busy, go to LOAD_TEST.
- LOAD_TEST: issue test_ren for f = 0..nf-1 on consecutive cycles. Capture returned data into local test_reg[f]. One cycle after the last read, go to CLEAR_SEL.
- CLEAR_SEL: pulse sel_clear for 1 cycle, then sel_start for 1 cycle, then go to COMPUTE with s = 0.
- COMPUTE: issue sample_ren at addr = s*NUM_FEATURES + f for f = 0..nf-1, one read per cycle.
  - Accumulate acc += |sample - test_reg[f]| on the returned data.
  - The accumulator clears on f = 0 data.
  - After the last data arrives, go to EMIT.
- EMIT: drive dist_valid = 1, dist_data = acc, dist_index = s.
  - Hold all three stable until dist_valid && dist_ready at a rising edge.
  - After the transfer: if s == ns-1, go to WAIT_SEL; else s++ and return to COMPUTE.
- WAIT_SEL: wait for sel_done. A sel_done seen in any other state is ignored.
- WRITEBACK: for i = 0..K-1 on consecutive cycles, assert kbest_wen with waddr = i and wdata = entry i of sel_indices_bus (sampled when sel_done was seen).
- FINISH: pulse done for 1 cycle, drop busy, return to IDLE.
- Arithmetic:
  - L1 absolute difference is unsigned DATA_WIDTH.
  - The accumulator is DIST_W wide and saturates at all-ones; with the defaults it never saturates.
- abort in any non-IDLE state:
  - Next cycle: all strobes and dist_valid are 0, sel_clear pulses once, no done pulse, busy drops, state goes to IDLE.
  - abort has priority over a simultaneous start or handshake.
- Asserting start and abort together in IDLE leaves the FSM in IDLE.
- An async rst mid-query behaves as a full reset; no partial writeback is completed.

Optional Feature:
KNN_SQ_DIST_EN:
- Defined: the per-feature term is (sample - test)^2, computed in 2*DATA_WIDTH bits. Accumulation saturates to DIST_W all-ones on overflow. COMPUTE adds one pipeline stage, so EMIT comes one cycle later per sample.
- Undefined: L1 distance as described above.

Decomposition:
- Package knn_pkg:
  - constants DATA_WIDTH, NUM_FEATURES, NUM_SAMPLES, K, DIST_W
  - derived widths IDX_W, FEAT_W, MEM_AW
  - FSM state enum {IDLE, LOAD_TEST, CLEAR_SEL, COMPUTE, EMIT, WAIT_SEL, WRITEBACK, FINISH}
- Sub-module knn_dist_accum: per-feature difference/square, saturating accumulator, clear and valid inputs, including the optional pipeline stage.

Test Plan:
- Training feature[s][f] = 10*s + f, test[f] = 100 + f, cfg 0/0 (full size), stub selector always ready:
  - dist stream is index s with distance 4*|10*s - 100|, e.g. s = 10 → 0, s = 9 → 40, s = 0 → 400.
  - Exactly 16 transfers, then 5 kbest writes matching sel_indices_bus, then done.
- Backpressure: dist_ready toggled 1-of-3 cycles → dist_data/dist_index held stable while not ready; no sample lost or duplicated; 16 transfers total.
- cfg_num_samples = 3, cfg_num_features = 2 → reads only addr {0,1,4,5,8,9}; distances 2*|10*s - 100| = 200, 180, 160; done after K writes.
- abort asserted in EMIT for s = 7 → dist_valid is 0 and sel_clear pulses the next cycle, no kbest_wen, no done, busy is 0. A new start then completes normally.
- start pulsed while busy → ignored; the query result is unchanged.
- With KNN_SQ_DIST_EN, sample 0 vs test (all 100+f) with full features → distance 4*100^2 = 40000; forced all-0xFFFF vs 0 data → DIST_W saturates to 0xFFFFFFFF.
